// File: rtl/mem_access_unit.sv
// RV64I sized load/store front-end for a doubleword-wide byte-array data memory.
// Sub-doubleword stores use a two-cycle read-modify-write; loads return a registered, extended result.
module mem_access_unit #(
   parameter int unsigned MEM_BYTES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_read,
   input  logic        req_write,
   input  logic [2:0]  funct3,
   input  logic [63:0] addr,
   input  logic [63:0] wdata,
   output logic        stall,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   output logic        mem_write,
   output logic        mem_read,
   input  logic [63:0] mem_rdata,
   output logic [63:0] load_data,
   output logic        load_valid,
   output logic        fault
);

   localparam logic [0:0]  ST_IDLE  = 1'b0;
   localparam logic [0:0]  ST_MERGE = 1'b1;
   localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);

   logic [0:0]  state_q, state_d;
   logic [63:0] buffer_q, buffer_d;
   logic [1:0]  size_q, size_d;
   logic [63:0] load_data_q, load_data_d;
   logic        load_valid_q, load_valid_d;
   logic        fault_q, fault_d;
   logic        misaligned;
   logic        illegal;

   function automatic logic [63:0] extend_load(input logic [2:0] f3, input logic [63:0] d);
      case (f3)
         3'b000:  extend_load = {{56{d[7]}}, d[7:0]};
         3'b001:  extend_load = {{48{d[15]}}, d[15:0]};
         3'b010:  extend_load = {{32{d[31]}}, d[31:0]};
         3'b100:  extend_load = {56'b0, d[7:0]};
         3'b101:  extend_load = {48'b0, d[15:0]};
         3'b110:  extend_load = {32'b0, d[31:0]};
         default: extend_load = d;
      endcase
   endfunction

   // Keep the untouched upper bytes of the doubleword read in the first RMW cycle.
   function automatic logic [63:0] merge_store(input logic [1:0] sz, input logic [63:0] old,
                                               input logic [63:0] wd);
      case (sz)
         2'b00:   merge_store = {old[63:8],  wd[7:0]};
         2'b01:   merge_store = {old[63:16], wd[15:0]};
         2'b10:   merge_store = {old[63:32], wd[31:0]};
         default: merge_store = wd;
      endcase
   endfunction

   always_comb begin
      misaligned = 1'b0;
      case (funct3[1:0])
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = addr[0];
         2'b10:   misaligned = |addr[1:0];
         default: misaligned = |addr[2:0];
      endcase
      illegal = (req_read | req_write) &
                ((req_read & req_write) |
                 (req_read & (funct3 == 3'b111)) |
                 (req_write & funct3[2]) |
                 misaligned |
                 (addr > ADDR_MAX));
   end

   assign mem_addr = addr;

   always_comb begin
      state_d      = state_q;
      buffer_d     = buffer_q;
      size_d       = size_q;
      load_data_d  = load_data_q;
      load_valid_d = 1'b0;
      fault_d      = 1'b0;
      stall        = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      mem_wdata    = wdata;

      case (state_q)
         ST_MERGE: begin
            // Inputs here belong to the held store; they are not re-decoded.
            mem_write = 1'b1;
            mem_wdata = merge_store(size_q, buffer_q, wdata);
            state_d   = ST_IDLE;
         end
         default: begin
            if (illegal) begin
               fault_d = 1'b1;
            end else if (req_read) begin
               mem_read     = 1'b1;
               load_valid_d = 1'b1;
               load_data_d  = extend_load(funct3, mem_rdata);
            end else if (req_write) begin
               if (funct3[1:0] == 2'b11) begin
                  mem_write = 1'b1;
               end else begin
                  mem_read = 1'b1;
                  stall    = 1'b1;
                  buffer_d = mem_rdata;
                  size_d   = funct3[1:0];
                  state_d  = ST_MERGE;
               end
            end
         end
      endcase

      if (reset) begin
         stall     = 1'b0;
         mem_read  = 1'b0;
         mem_write = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         buffer_q     <= '0;
         size_q       <= '0;
         load_data_q  <= '0;
         load_valid_q <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         buffer_q     <= buffer_d;
         size_q       <= size_d;
         load_data_q  <= load_data_d;
         load_valid_q <= load_valid_d;
         fault_q      <= fault_d;
      end
   end

   assign load_data  = load_data_q;
   assign load_valid = load_valid_q;
   assign fault      = fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed plan then random loads/stores against a byte-array reference model.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_read, req_write;
   logic [2:0]  funct3;
   logic [63:0] addr, wdata;
   logic        stall, mem_write, mem_read, load_valid, fault;
   logic [63:0] mem_addr, mem_wdata, mem_rdata, load_data;

   logic [7:0]  dut_mem [64];
   logic [7:0]  ref_mem [64];
   bit          mem_seed = 1'b1;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [63:0] exp_ld = '0;

   mem_access_unit #(.MEM_BYTES(64)) dut (
      .clk(clk), .reset(reset), .req_read(req_read), .req_write(req_write),
      .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
      .mem_read(mem_read), .mem_rdata(mem_rdata), .load_data(load_data),
      .load_valid(load_valid), .fault(fault)
   );

   always #5 clk = ~clk;

   // Data memory seen by the DUT, written only through its strobes.
   always @(posedge clk) begin
      if (mem_seed) begin
         for (int k = 0; k < 64; k++) dut_mem[k] <= (k >= 8 && k <= 41) ? 8'(k) : 8'h00;
      end else if (mem_write && mem_addr <= 64'd56) begin
         for (int i = 0; i < 8; i++) dut_mem[int'(mem_addr[5:0]) + i] <= mem_wdata[8*i +: 8];
      end
   end

   always_comb begin
      mem_rdata = '0;
      if (mem_addr <= 64'd56)
         for (int i = 0; i < 8; i++) mem_rdata[8*i +: 8] = dut_mem[int'(mem_addr[5:0]) + i];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_read(input int unsigned a, input int unsigned n, input bit sgn);
      logic [63:0] v;
      v = '0;
      for (int i = 0; i < 8; i++) if (i < int'(n)) v[8*i +: 8] = ref_mem[a + 32'(i)];
      if (sgn && n < 8 && v[8*n-1])
         for (int i = 0; i < 64; i++) if (i >= int'(8*n)) v[i] = 1'b1;
      return v;
   endfunction

   function automatic bit ref_legal(input bit rd, input bit wr, input logic [2:0] f3, input int unsigned a);
      int unsigned sz;
      sz = 32'd1 << f3[1:0];
      if (!rd && !wr) return 1'b0;
      if (rd && wr) return 1'b0;
      if (rd && f3 == 3'd7) return 1'b0;
      if (wr && f3[2]) return 1'b0;
      if (a % sz != 0) return 1'b0;
      if (a > 56) return 1'b0;
      return 1'b1;
   endfunction

   task automatic do_req(input bit rd, input bit wr, input logic [2:0] f3, input int unsigned a,
                         input logic [63:0] wd, input bit rst_merge);
      bit          legal, rmw;
      int unsigned n;
      logic [63:0] merged;
      legal = ref_legal(rd, wr, f3, a);
      n     = 32'd1 << f3[1:0];
      rmw   = legal && wr && (n < 8);
      @(negedge clk);
      req_read = rd; req_write = wr; funct3 = f3; addr = 64'(a); wdata = wd;
      #1;
      check("stall", 64'(stall), 64'(rmw));
      check("mem_read", 64'(mem_read), 64'(legal && (rd || rmw)));
      check("mem_write", 64'(mem_write), 64'(legal && wr && !rmw));
      check("mem_addr", mem_addr, 64'(a));
      if (legal && wr && !rmw) check("sd_wdata", mem_wdata, wd);
      @(posedge clk);
      #1;
      check("fault", 64'(fault), 64'(!legal));
      check("load_valid", 64'(load_valid), 64'(legal && rd));
      if (legal && rd) exp_ld = ref_read(a, n, !f3[2]);
      check("load_data", load_data, exp_ld);
      if (legal && wr && !rmw)
         for (int i = 0; i < 8; i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
      if (rmw) begin
         merged = ref_read(a, 8, 1'b0);
         for (int i = 0; i < 8; i++) if (i < int'(n)) merged[8*i +: 8] = wd[8*i +: 8];
         @(negedge clk);
         if (rst_merge) reset = 1'b1;
         #1;
         check("merge_stall", 64'(stall), 64'd0);
         check("merge_read", 64'(mem_read), 64'd0);
         check("merge_write", 64'(mem_write), 64'(!rst_merge));
         if (!rst_merge) check("merge_wdata", mem_wdata, merged);
         @(posedge clk);
         #1;
         if (rst_merge) begin
            reset  = 1'b0;
            exp_ld = '0;
         end else begin
            for (int i = 0; i < 8; i++) ref_mem[a + 32'(i)] = merged[8*i +: 8];
         end
         check("merge_fault", 64'(fault), 64'd0);
         check("merge_lvalid", 64'(load_valid), 64'd0);
         check("merge_ldata", load_data, exp_ld);
      end
      req_read = 1'b0; req_write = 1'b0;
   endtask

   bit          r_rd, r_wr, r_rst;
   logic [2:0]  r_f3;
   int unsigned r_a, r_kind;
   logic [63:0] r_d0, r_d1;

   initial begin
      for (int k = 0; k < 64; k++) ref_mem[k] = (k >= 8 && k <= 41) ? 8'(k) : 8'h00;
      reset = 1'b1; req_read = 1'b0; req_write = 1'b1; funct3 = 3'd0; addr = 64'd8; wdata = '0;
      @(posedge clk);
      #1 mem_seed = 1'b0;
      @(negedge clk);
      #1;
      check("rst_stall", 64'(stall), 64'd0);
      check("rst_mem_read", 64'(mem_read), 64'd0);
      check("rst_mem_write", 64'(mem_write), 64'd0);
      @(posedge clk);
      #1;
      check("rst_load_data", load_data, 64'd0);
      check("rst_load_valid", 64'(load_valid), 64'd0);
      check("rst_fault", 64'(fault), 64'd0);
      reset = 1'b0; req_write = 1'b0;

      do_req(1, 0, 3'b011, 8, '0, 0);
      check("plan_ld8", load_data, 64'h0F0E0D0C0B0A0908);
      do_req(0, 1, 3'b000, 9, 64'hFF, 0);
      do_req(1, 0, 3'b011, 8, '0, 0);
      check("plan_ld8_after_sb", load_data, 64'h0F0E0D0C0B0AFF08);
      do_req(0, 1, 3'b001, 16, 64'h8001, 0);
      do_req(1, 0, 3'b001, 16, '0, 0);
      check("plan_lh16", load_data, 64'hFFFFFFFFFFFF8001);
      do_req(1, 0, 3'b101, 16, '0, 0);
      check("plan_lhu16", load_data, 64'h0000000000008001);
      do_req(1, 0, 3'b010, 10, '0, 0);
      do_req(1, 0, 3'b011, 60, '0, 0);
      do_req(0, 1, 3'b010, 24, 64'hDEADBEEF, 1);
      do_req(1, 0, 3'b011, 24, '0, 0);
      check("plan_ld24", load_data, 64'h1F1E1D1C1B1A1918);
      do_req(0, 1, 3'b011, 32, 64'h1122334455667788, 0);
      do_req(1, 0, 3'b000, 39, '0, 0);
      check("plan_lb39", load_data, 64'h0000000000000011);
      do_req(1, 0, 3'b111, 8, '0, 0);
      do_req(0, 1, 3'b100, 8, 64'h55, 0);
      do_req(1, 1, 3'b011, 8, 64'h55, 0);
      do_req(0, 1, 3'b000, 56, 64'hA5, 0);
      do_req(1, 0, 3'b011, 56, '0, 0);

      for (int k = 0; k < 120; k++) begin
         r_kind = $urandom_range(0, 9);
         r_rd   = (r_kind < 5) || (r_kind == 9);
         r_wr   = (r_kind >= 5);
         r_f3   = 3'($urandom_range(0, 7));
         if (r_wr && !r_rd && $urandom_range(0, 4) != 0) r_f3[2] = 1'b0;
         r_a    = $urandom_range(0, 63);
         if ($urandom_range(0, 4) != 0) r_a = r_a & ~((32'd1 << r_f3[1:0]) - 1);
         r_d0   = {$urandom, $urandom};
         r_rst  = r_wr && !r_rd && ($urandom_range(0, 9) == 0);
         do_req(r_rd, r_wr, r_f3, r_a, r_d0, r_rst);
      end

      for (int w = 0; w < 8; w++) begin
         for (int i = 0; i < 8; i++) begin
            r_d0[8*i +: 8] = dut_mem[8*w + i];
            r_d1[8*i +: 8] = ref_mem[8*w + i];
         end
         check($sformatf("mem_dword%0d", w), r_d0, r_d1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
